// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide, XLEN+1 latency.
// Define MDU_FAST_MUL_EN to compute MUL/MULH/MULHU with a single-cycle combinational product.
module mdu_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhu = 3'd2, OpDiv = 3'd3,
                           OpMod = 3'd4, OpDivu = 3'd5, OpModu = 3'd6, OpRsvd = 3'd7;
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   work_q, work_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [TAG_W-1:0]    tag_q, tag_d;

    // Accept-side operand conditioning
    logic            sgn_op, in_is_div, in_is_mul, div0, ovf, neg1, neg2;
    logic [XLEN-1:0] abs1, abs2, early_res;

    always_comb begin
        sgn_op    = (in_op == OpMulh) || (in_op == OpDiv) || (in_op == OpMod);
        in_is_div = (in_op >= OpDiv) && (in_op <= OpModu);
        in_is_mul = (in_op <= OpMulhu);
        neg1      = sgn_op & in_src1[XLEN-1];
        neg2      = sgn_op & in_src2[XLEN-1];
        abs1      = neg1 ? (XLEN'(0) - in_src1) : in_src1;
        abs2      = neg2 ? (XLEN'(0) - in_src2) : in_src2;
        div0      = in_is_div && (in_src2 == '0);
        ovf       = ((in_op == OpDiv) || (in_op == OpMod)) && (in_src1 == MinVal) &&
                    (in_src2 == '1);
        early_res = '0;
        if (div0) early_res = ((in_op == OpDiv) || (in_op == OpDivu)) ? '1 : in_src1;
        else if (ovf) early_res = (in_op == OpDiv) ? MinVal : '0;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    logic [XLEN-1:0]   fast_res;
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
        fast_fix  = (neg1 ^ neg2) ? ((2*XLEN)'(0) - fast_prod) : fast_prod;
        fast_res  = (in_op == OpMul) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
    end
`endif

    // One iteration step on the working register
    logic              is_div_q, div_ge;
    logic [XLEN:0]     mul_sum, div_sh, div_sub;
    logic [2*XLEN-1:0] step, fix_full;
    logic [XLEN-1:0]   rem_fix, fin_res;

    always_comb begin
        is_div_q = (op_q >= OpDiv);
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_ge   = div_sh >= {1'b0, opnd_q};
        div_sub  = div_sh - {1'b0, opnd_q};
        if (is_div_q)
            step = {(div_ge ? div_sub[XLEN-1:0] : div_sh[XLEN-1:0]), work_q[XLEN-2:0], div_ge};
        else
            step = {mul_sum, work_q[XLEN-1:1]};
        fix_full = neg_q ? ((2*XLEN)'(0) - step) : step;
        rem_fix  = neg_q ? (XLEN'(0) - step[2*XLEN-1:XLEN]) : step[2*XLEN-1:XLEN];
        unique case (op_q)
            OpMulh, OpMulhu: fin_res = fix_full[2*XLEN-1:XLEN];
            OpMod, OpModu:   fin_res = rem_fix;
            default:         fin_res = fix_full[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        res_d   = res_q;
        tag_d   = tag_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (in_valid) begin
                    op_d  = in_op;
                    tag_d = in_tag;
                    neg_d = (in_op == OpMod) ? neg1 : (neg1 ^ neg2);
                    if (div0 || ovf || (in_op == OpRsvd)) begin
                        res_d   = early_res;
                        state_d = StDone;
`ifdef MDU_FAST_MUL_EN
                    end else if (in_is_mul) begin
                        res_d   = fast_res;
                        state_d = StDone;
`endif
                    end else begin
                        // Divide: {rem, quotient}; multiply: {acc, multiplier}
                        work_d  = {{XLEN{1'b0}}, (in_is_div ? abs1 : abs2)};
                        opnd_d  = in_is_div ? abs2 : abs1;
                        cnt_d   = CW'(XLEN);
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    work_d = step;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_d   = fin_res;
                        state_d = StDone;
                    end
                end
                StDone: if (out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_result = res_q;
    assign out_tag    = tag_q;

    logic unused_ok;
    assign unused_ok = in_is_mul;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        logic [63:0]     p;
        logic            ov;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = ua * ub; return p[63:32]; end
            3'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return a;
                p = sa / sb; return p[31:0];
            end
            3'd4: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op == 3'd7) return 1;
        if (op >= 3'd3 && b == 0) return 1;
        if ((op == 3'd3 || op == 3'd4) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
        if (op <= 3'd2) return 1;
`endif
        return 33;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    // Issue one op, wait for its result, hold out_ready low for 'hold' cycles, then retire it.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold);
        int   cyc;
        logic busy_bad;
        logic [31:0] exp;
        exp = ref_res(op, a, b);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
        out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_src1 = $urandom; in_src2 = $urandom; in_tag = 5'($urandom);
        cyc = 1; busy_bad = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); @(negedge clk); cyc++;
        end
        check("latency", 64'(cyc), 64'(ref_lat(op, a, b)));
        check("busy_in_ready", {63'b0, busy_bad}, 0);
        check($sformatf("result op%0d a=%h b=%h", op, a, b), {32'b0, out_result}, {32'b0, exp});
        check("tag", {59'b0, out_tag}, {59'b0, tag});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_result", {32'b0, out_result}, {32'b0, exp});
            check("hold_tag", {59'b0, out_tag}, {59'b0, tag});
            check("hold_state", {62'b0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("retire_state", {62'b0, out_valid, in_ready}, 64'b01);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {62'b0, out_valid, in_ready}, 64'b01);
        check("reset_result", {32'b0, out_result}, 0);
        check("reset_tag", {59'b0, out_tag}, 0);
        rst = 1'b0;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd1, 5'd4, 0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        do_op(3'd3, 32'd5, 32'd0, 5'd9, 0);
        do_op(3'd6, 32'd5, 32'd0, 5'd10, 0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        do_op(3'd7, 32'd9, 32'd9, 5'd13, 0);
        do_op(3'd3, 32'd1000, 32'hFFFF_FFF9, 5'd14, 5);

        // Flush a DIV at cycle 10; its result must never appear
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd3; in_src1 = 32'd12345; in_src2 = 32'd17; in_tag = 5'd3;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {63'b0, in_ready}, 1);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            @(posedge clk); @(negedge clk);
        end
        check("flush_no_valid", 64'(seen), 0);
        do_op(3'd5, 32'd100, 32'd7, 5'd4, 0);

        // A request presented together with flush is dropped
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd7; in_tag = 5'd21;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_same_cycle", {62'b0, out_valid, in_ready}, 64'b01);

        // Reset mid-op clears outputs
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_src1 = 32'd3; in_src2 = 32'd5; in_tag = 5'd9;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", {62'b0, out_valid, in_ready}, 64'b01);
        check("rst_mid_out", {27'b0, out_tag, out_result}, 0);

        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 5'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
